nco_phase_acc: RTL

Phase-accumulator front end of the NCO. Advances a wide phase register once per audio sample strobe and drives the truncated phase index into the sine lookup table. One cycle later it registers the table's combinational output as the sample presented to downstream effects (tremolo/vibrato LFO, test tone). Tuning-word changes arrive over a valid/ready handshake and are applied glitch-free on sample boundaries.

---
 rtl/nco_phase_acc.sv | 109 ++++++++++
 1 files changed

// File: rtl/nco_phase_acc.sv
// Phase accumulator for the NCO: steps phase on each sample strobe and drives the LUT index.
// It registers the LUT sample and accepts tuning words that are applied only on sample boundaries.
module nco_phase_acc #(
    parameter int                   ACC_WIDTH    = 32,
    parameter int                   PHI_WIDTH    = 8,
    parameter int                   WAV_WIDTH    = 24,
    parameter logic [ACC_WIDTH-1:0] FTW_RESET    = 32'h0100_0000,
    parameter int                   SYNC_ON_WRAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 phase_rst,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    output logic [PHI_WIDTH-1:0] phi,
    input  logic [WAV_WIDTH-1:0] wav_in,
    output logic [WAV_WIDTH-1:0] wav_out,
    output logic                 wav_valid,
    output logic                 wrap
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] ftw_active_reg;
    logic [ACC_WIDTH-1:0] ftw_pend_reg;
    logic [0:0]           state_reg;
    logic                 carry_d_reg;
    logic                 cap_d_reg;
    logic [WAV_WIDTH-1:0] wav_out_reg;
    logic                 wav_valid_reg;
    logic                 wrap_reg;

    logic [ACC_WIDTH:0]   sum_next;
    logic                 step_en;
    logic                 apply_en;
    logic                 accept_en;

    // Extra top bit of the sum is the carry out of the accumulator.
    assign sum_next  = {1'b0, acc_reg} + {1'b0, ftw_active_reg};
    assign step_en   = sample_en & ~phase_rst;
    assign apply_en  = (state_reg == ST_PENDING) & step_en &
                       ((SYNC_ON_WRAP == 0) | sum_next[ACC_WIDTH]);
    assign accept_en = (state_reg == ST_IDLE) & ftw_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            carry_d_reg <= 1'b0;
            cap_d_reg   <= 1'b0;
        end else begin
            if (phase_rst) begin
                acc_reg <= '0;
            end else if (sample_en) begin
                acc_reg <= sum_next[ACC_WIDTH-1:0];
            end
            carry_d_reg <= step_en & sum_next[ACC_WIDTH];
            cap_d_reg   <= step_en;
        end
    end

    // Word in flight is only committed on a strobe edge, so the phase never sees a mid-sample change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ftw_active_reg <= FTW_RESET;
            ftw_pend_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept_en) begin
                        ftw_pend_reg <= ftw_in;
                        state_reg    <= ST_PENDING;
                    end
                end
                default: begin
                    if (apply_en) begin
                        ftw_active_reg <= ftw_pend_reg;
                        state_reg      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wav_out_reg   <= '0;
            wav_valid_reg <= 1'b0;
            wrap_reg      <= 1'b0;
        end else begin
            if (cap_d_reg) begin
                wav_out_reg <= wav_in;
            end
            wav_valid_reg <= cap_d_reg;
            wrap_reg      <= cap_d_reg & carry_d_reg;
        end
    end

    assign ftw_ready = (state_reg == ST_IDLE);
    assign phi       = acc_reg[ACC_WIDTH-1 -: PHI_WIDTH];
    assign wav_out   = wav_out_reg;
    assign wav_valid = wav_valid_reg;
    assign wrap      = wrap_reg;

endmodule
